// File: rtl/div_sequencer.sv
// div_sequencer: owns the shared iterative divider, holds HI/LO, and stalls
// the execute stage while a divide is outstanding (with a watchdog on the wait).
module div_sequencer #(
  parameter logic [3:0] DIV_OP  = 4'b1001,
  parameter int         TIMEOUT = 64,
  parameter int         CNT_W   = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic [2:0]  op_code,
  input  logic [15:0] op_a,
  input  logic [15:0] op_b,
  output logic        op_ready,
  output logic        stall,
  output logic [15:0] rd_data,
  output logic        rd_valid,
  output logic [3:0]  div_control,
  output logic [15:0] div_dividend,
  output logic [15:0] div_divisor,
  input  logic        div_validity,
  input  logic [31:0] div_result,
  output logic [15:0] hi,
  output logic [15:0] lo,
  output logic        dz_err,
  output logic        timeout_err
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_t;

  localparam logic [2:0] OP_DIV  = 3'b001;
  localparam logic [2:0] OP_MFHI = 3'b010;
  localparam logic [2:0] OP_MFLO = 3'b011;
  localparam logic [2:0] OP_MTHI = 3'b100;
  localparam logic [2:0] OP_MTLO = 3'b101;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             div_go;
  logic             cnt_expired;

  assign op_ready    = (state == IDLE);
  assign stall       = op_valid & ~op_ready;
  assign accept      = op_valid & op_ready;
  assign div_go      = accept && (op_code == OP_DIV) && (op_b != 16'h0000);
  assign cnt_expired = (cnt == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (div_go) next_state = ISSUE;
      ISSUE:   next_state = WAIT;
      WAIT:    if (div_validity || cnt_expired) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Zero divisors are resolved here so the divider never sees one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi           <= 16'h0000;
      lo           <= 16'h0000;
      rd_data      <= 16'h0000;
      rd_valid     <= 1'b0;
      div_control  <= 4'b0000;
      div_dividend <= 16'h0000;
      div_divisor  <= 16'h0000;
      dz_err       <= 1'b0;
      timeout_err  <= 1'b0;
      cnt          <= '0;
    end else begin
      rd_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            case (op_code)
              OP_DIV: begin
                if (op_b != 16'h0000) begin
                  div_dividend <= op_a;
                  div_divisor  <= op_b;
                  div_control  <= DIV_OP;
                  dz_err       <= 1'b0;
                end else begin
                  hi     <= op_a;
                  lo     <= 16'hFFFF;
                  dz_err <= 1'b1;
                end
              end
              OP_MFHI: begin
                rd_data  <= hi;
                rd_valid <= 1'b1;
              end
              OP_MFLO: begin
                rd_data  <= lo;
                rd_valid <= 1'b1;
              end
              OP_MTHI: hi <= op_a;
              OP_MTLO: lo <= op_a;
              default: ;
            endcase
          end
        end
        ISSUE: cnt <= '0;
        WAIT: begin
          if (div_validity) begin
            hi          <= div_result[31:16];
            lo          <= div_result[15:0];
            div_control <= 4'b0000;
          end else if (cnt_expired) begin
            timeout_err <= 1'b1;
            div_control <= 4'b0000;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
